mul_result_buffer: RTL

Result stage directly downstream of the 16x16 sequential Booth multiplier datapath/controller. It captures each signed 32-bit product on the controller's one-cycle completion pulse, tagged with a caller-supplied ID, and queues it in a small FIFO. It presents results to the consumer over a valid/ready handshake and returns `in_ready` to the controller as back-pressure, so a new multiplication is started only when a result slot is free.

---
 rtl/mul_result_buffer.sv | 97 +++++++++
 1 files changed

// File: rtl/mul_result_buffer.sv
// Result FIFO behind the sequential Booth multiplier: captures tagged signed products and hands them out over valid/ready.
// Optional macro RESULT_SAT16_EN adds 16-bit saturated head outputs (out_sat16, out_sat_flag).
module mul_result_buffer #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       in_valid,
  input  logic [31:0]                in_product,
  input  logic [TAG_W-1:0]           in_tag,
  output logic                       in_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_product,
  output logic [TAG_W-1:0]           out_tag,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
`ifdef RESULT_SAT16_EN
  ,
  output logic [15:0]                out_sat16,
  output logic                       out_sat_flag
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]      r_mem_prod [DEPTH];
  logic [TAG_W-1:0] r_mem_tag  [DEPTH];
  logic [PW-1:0]    r_rd_ptr;
  logic [PW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;
  logic             r_overflow;

  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic [31:0]      w_head_prod;
  logic [TAG_W-1:0] w_head_tag;

  assign w_full      = (r_count == CW'(DEPTH));
  assign in_ready    = !w_full || out_ready;
  assign out_valid   = (r_count != '0);
  assign w_push      = in_valid && in_ready;
  assign w_pop       = out_valid && out_ready;
  assign w_head_prod = r_mem_prod[r_rd_ptr];
  assign w_head_tag  = r_mem_tag[r_rd_ptr];

  // Head data is gated so stale array contents never leak after a pop, clear or reset.
  assign out_product = out_valid ? w_head_prod : '0;
  assign out_tag     = out_valid ? w_head_tag  : '0;
  assign count       = r_count;
  assign overflow    = r_overflow;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (clear) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_push && !w_pop)
        r_count <= r_count + CW'(1);
      else if (w_pop && !w_push)
        r_count <= r_count - CW'(1);
      if (in_valid && !in_ready) r_overflow <= 1'b1;
    end
  end

  // Storage has no reset so it can map onto plain registers/LUT RAM.
  always_ff @(posedge clk) begin
    if (w_push && !clear) begin
      r_mem_prod[r_wr_ptr] <= in_product;
      r_mem_tag[r_wr_ptr]  <= in_tag;
    end
  end

`ifdef RESULT_SAT16_EN
  logic w_fits16;
  // Fits in 16 bits when bits 31..15 are all copies of the sign.
  assign w_fits16     = (&w_head_prod[31:15]) || !(|w_head_prod[31:15]);
  assign out_sat_flag = out_valid && !w_fits16;
  assign out_sat16    = !out_valid ? 16'h0000 :
                        w_fits16   ? w_head_prod[15:0] :
                        w_head_prod[31] ? 16'h8000 : 16'h7FFF;
`endif

endmodule
